mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, between EX and WB. Latches EX_to_MEM_bus and

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: holds one instruction from EX, runs its load/store
// on the req/addr_ok/data_ok data port, extends load data and forwards results to WB and ID.
module mem_stage #(
  parameter int EX_TO_MEM_BUS_WD = 109,
  parameter int MEM_TO_WB_BUS_WD = 104,
  parameter int MEM_TO_ID_BUS_WD = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        EX_to_MEM_valid,
  output logic                        MEM_allow_in,
  input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
  output logic                        MEM_to_WB_valid,
  input  logic                        WB_allow_in,
  output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
  output logic [MEM_TO_ID_BUS_WD-1:0] MEM_to_ID_bus,
  output logic                        data_sram_req,
  output logic                        data_sram_wr,
  output logic [1:0]                  data_sram_size,
  output logic [3:0]                  data_sram_wstrb,
  output logic [31:0]                 data_sram_addr,
  output logic [31:0]                 data_sram_wdata,
  input  logic                        data_sram_addr_ok,
  input  logic                        data_sram_data_ok,
  input  logic [31:0]                 data_sram_rdata,
  output logic [1:0]                  mem_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready (allow_in / addr_ok) are both
  // high at the rising edge; valid and the payload stay stable until that transfer happens.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      state, state_nxt;
  logic                        mem_valid;
  logic [EX_TO_MEM_BUS_WD-1:0] ex_bus;
  logic [31:0]                 load_buf;
  logic                        load_capture;

  logic [31:0] pc_plus_4, alu_res, store_data;
  logic        mem_re, mem_we, mem_sign, sel_rf_w_en;
  logic [1:0]  mem_size, sel_rf_w_data;
  logic [4:0]  rf_waddr;

  assign pc_plus_4     = ex_bus[108:77];
  assign alu_res       = ex_bus[76:45];
  assign store_data    = ex_bus[44:13];
  assign mem_re        = ex_bus[12];
  assign mem_we        = ex_bus[11];
  assign mem_size      = ex_bus[10:9];
  assign mem_sign      = ex_bus[8];
  assign rf_waddr      = ex_bus[7:3];
  assign sel_rf_w_data = ex_bus[2:1];
  assign sel_rf_w_en   = ex_bus[0];

  logic mem_op, ready_go, accept, handoff, in_mem_op;

  assign mem_op          = mem_re | mem_we;
  assign in_mem_op       = EX_to_MEM_bus[12] | EX_to_MEM_bus[11];
  assign ready_go        = mem_valid & (~mem_op | (state == S_DONE));
  assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
  assign MEM_to_WB_valid = ready_go;
  assign accept          = EX_to_MEM_valid & MEM_allow_in;
  assign handoff         = ready_go & WB_allow_in;

  // Effective address: word and half accesses are forced to their natural alignment.
  logic [31:0] eff_addr;
  always_comb begin
    eff_addr = alu_res;
    if (mem_size[1])      eff_addr = {alu_res[31:2], 2'b00};
    else if (mem_size[0]) eff_addr = {alu_res[31:1], 1'b0};
  end

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = store_data;
    case (mem_size)
      2'b00: begin
        data_sram_wdata = {4{store_data[7:0]}};
        if (mem_we) data_sram_wstrb = 4'b0001 << eff_addr[1:0];
      end
      2'b01: begin
        data_sram_wdata = {2{store_data[15:0]}};
        if (mem_we) data_sram_wstrb = eff_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (mem_we) data_sram_wstrb = 4'b1111;
      end
    endcase
  end

  assign data_sram_req  = (state == S_REQ);
  assign data_sram_wr   = mem_we;
  assign data_sram_size = mem_size;
  assign data_sram_addr = eff_addr;

  logic [15:0] lane;
  logic [31:0] load_ext;
  assign lane = 16'(data_sram_rdata >> {eff_addr[1:0], 3'b000});

  always_comb begin
    case (mem_size)
      2'b00:   load_ext = {{24{mem_sign & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{mem_sign & lane[15]}}, lane[15:0]};
      default: load_ext = data_sram_rdata;
    endcase
  end

  // A new accept overrides any in-progress transition; accept is only possible once the
  // current instruction is leaving or the stage is empty.
  always_comb begin
    state_nxt    = state;
    load_capture = 1'b0;
    case (state)
      S_REQ: begin
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            state_nxt    = S_DONE;
            load_capture = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          state_nxt    = S_DONE;
          load_capture = 1'b1;
        end
      end
      default: state_nxt = state;
    endcase
    if (accept)       state_nxt = in_mem_op ? S_REQ : S_IDLE;
    else if (handoff) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_valid <= 1'b0;
      ex_bus    <= '0;
      load_buf  <= '0;
    end else begin
      state <= state_nxt;
      if (MEM_allow_in) mem_valid <= EX_to_MEM_valid;
      if (accept) ex_bus <= EX_to_MEM_bus;
      if (load_capture) load_buf <= load_ext;
    end
  end

  logic [31:0] load_data, fwd_data;
  logic        load_done, load_pending;

  assign load_done    = mem_re & (state == S_DONE);
  assign load_pending = mem_valid & mem_re & (state != S_DONE);
  assign load_data    = mem_re ? load_buf : 32'd0;

  always_comb begin
    if (load_done)                   fwd_data = load_data;
    else if (sel_rf_w_data == 2'b01) fwd_data = pc_plus_4 + 32'd4;
    else                             fwd_data = alu_res;
  end

  assign MEM_to_WB_bus = {pc_plus_4, alu_res, load_data, rf_waddr, sel_rf_w_data, sel_rf_w_en};
  assign MEM_to_ID_bus = {load_pending, fwd_data, rf_waddr, sel_rf_w_en & mem_valid, mem_valid};
  assign mem_state     = state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model of the MEM stage and of a data memory with
// random addr_ok/data_ok latencies, compared against the DUT every cycle.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         EX_to_MEM_valid;
  logic         MEM_allow_in;
  logic [108:0] EX_to_MEM_bus;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [103:0] MEM_to_WB_bus;
  logic [39:0]  MEM_to_ID_bus;
  logic         data_sram_req, data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [1:0]   mem_state;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .EX_to_MEM_valid(EX_to_MEM_valid), .MEM_allow_in(MEM_allow_in), .EX_to_MEM_bus(EX_to_MEM_bus),
    .MEM_to_WB_valid(MEM_to_WB_valid), .WB_allow_in(WB_allow_in), .MEM_to_WB_bus(MEM_to_WB_bus),
    .MEM_to_ID_bus(MEM_to_ID_bus),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_state(mem_state)
  );

  typedef struct {
    logic [31:0] pc4, alu, sd;
    logic        re, we, sign, en;
    logic [1:0]  size, sel;
    logic [4:0]  waddr;
    int          addr_dly, data_dly, wb_stall;
  } instr_t;

  instr_t       pend_q[$];
  instr_t       pres, cur;
  logic [103:0] exp_q[$];
  logic [70:0]  req_q[$];
  logic [31:0]  mem_words[logic [31:0]];

  int checks = 0, errors = 0;
  bit presenting, in_mem, cur_reqd, cur_done, stray_en, stray_force;
  int cur_acnt, cur_dcnt, cur_stall;
  int ex_rate = 100;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_read(logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    if (mem_words.exists(w)) return mem_words[w];
    return w * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic bit is_mem(instr_t i);
    return i.re || i.we;
  endfunction

  function automatic logic [31:0] eff_addr(instr_t i);
    if (i.size == 2'd2) return i.alu & ~32'd3;
    if (i.size == 2'd1) return i.alu & ~32'd1;
    return i.alu;
  endfunction

  function automatic logic [31:0] load_val(instr_t i);
    logic [31:0] a = eff_addr(i);
    logic [31:0] w = mem_read(a);
    logic [31:0] v;
    int sh = 8 * int'(a % 32'd4);
    if (!i.re) return 32'd0;
    if (i.size == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (i.sign && v >= 32'h80) v = v - 32'h100;
    end else if (i.size == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (i.sign && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [70:0] exp_req(instr_t i);
    logic [31:0] a = eff_addr(i);
    logic [3:0]  strb = 4'd0;
    logic [31:0] wd = i.sd;
    if (i.size == 2'd0) wd = (i.sd & 32'hFF) * 32'h0101_0101;
    if (i.size == 2'd1) wd = (i.sd & 32'hFFFF) * 32'h0001_0001;
    if (i.we) begin
      if (i.size == 2'd0)      strb = 4'(1 << (a % 32'd4));
      else if (i.size == 2'd1) strb = 4'(3 << (a % 32'd4));
      else                     strb = 4'hF;
    end
    return {i.we, i.size, strb, a, wd};
  endfunction

  function automatic logic [103:0] exp_wb(instr_t i);
    return {i.pc4, i.alu, load_val(i), i.waddr, i.sel, i.en};
  endfunction

  function automatic logic [108:0] pack_ex(instr_t i);
    return {i.pc4, i.alu, i.sd, i.re, i.we, i.size, i.sign, i.waddr, i.sel, i.en};
  endfunction

  function automatic instr_t mk(logic re, logic we, logic [1:0] size, logic sign,
                                logic [31:0] alu, logic [31:0] sd, int ad, int dd, int st);
    instr_t i;
    i.pc4 = $urandom; i.alu = alu; i.sd = sd; i.re = re; i.we = we; i.size = size;
    i.sign = sign; i.waddr = 5'($urandom_range(31)); i.sel = 2'($urandom_range(3));
    i.en = 1'($urandom_range(1)); i.addr_dly = ad; i.data_dly = dd; i.wb_stall = st;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    int k = $urandom_range(9);
    return mk(k >= 4 && k <= 6, k >= 7, 2'($urandom_range(2)), 1'($urandom_range(1)),
              $urandom, $urandom, $urandom_range(3), $urandom_range(3), $urandom_range(2));
  endfunction

  // ---------------- one clock cycle of drive, check and model update ----------------
  task automatic step();
    logic [127:0] rnd;
    logic [70:0]  e;
    logic [31:0]  fwd;
    bit rdy, wb, exp_allow, exp_req_on, aok, dok, real_dok;
    @(negedge clk);
    if (!presenting && pend_q.size() > 0 && $urandom_range(99) < ex_rate) begin
      pres = pend_q.pop_front();
      presenting = 1;
    end
    rnd = {$urandom, $urandom, $urandom, $urandom};
    EX_to_MEM_valid = presenting;
    EX_to_MEM_bus = presenting ? pack_ex(pres) : rnd[108:0];

    rdy = in_mem && (!is_mem(cur) || cur_done);
    if (rdy && cur_stall > 0) begin
      wb = 0;
      cur_stall--;
    end else if (rdy) wb = 1;
    else wb = 1'($urandom_range(1));
    WB_allow_in = wb;

    aok = 0; dok = 0; real_dok = 0;
    if (in_mem && is_mem(cur) && !cur_reqd) begin
      if (cur_acnt >= cur.addr_dly) begin
        aok = 1;
        if (cur.data_dly == 0) begin dok = 1; real_dok = 1; end
      end else cur_acnt++;
    end else if (in_mem && is_mem(cur) && !cur_done) begin
      if (cur_dcnt >= cur.data_dly) begin dok = 1; real_dok = 1; end
      else cur_dcnt++;
    end else if (stray_force || (stray_en && $urandom_range(7) == 0)) begin
      dok = 1;
    end
    stray_force = 0;
    data_sram_addr_ok = aok;
    data_sram_data_ok = dok;
    data_sram_rdata = real_dok ? mem_read(eff_addr(cur)) : $urandom;

    #1;
    check("wb_valid", 128'(MEM_to_WB_valid), 128'(rdy));
    exp_allow = !in_mem || (rdy && wb);
    check("allow_in", 128'(MEM_allow_in), 128'(exp_allow));
    exp_req_on = in_mem && is_mem(cur) && !cur_reqd;
    check("sram_req", 128'(data_sram_req), 128'(exp_req_on));
    if (exp_req_on) begin
      if (req_q.size() == 0) check("req_queue", 128'(0), 128'(1));
      else begin
        e = req_q[0];
        check("req_wr", 128'(data_sram_wr), 128'(e[70]));
        check("req_size", 128'(data_sram_size), 128'(e[69:68]));
        check("req_wstrb", 128'(data_sram_wstrb), 128'(e[67:64]));
        check("req_addr", 128'(data_sram_addr), 128'(e[63:32]));
        if (e[70]) check("req_wdata", 128'(data_sram_wdata), 128'(e[31:0]));
        if (aok) void'(req_q.pop_front());
      end
    end
    if (rdy) begin
      if (exp_q.size() == 0) check("wb_queue", 128'(0), 128'(1));
      else begin
        check("wb_bus", 128'(MEM_to_WB_bus), 128'(exp_q[0]));
        if (wb) void'(exp_q.pop_front());
      end
    end
    check("id_valid", 128'(MEM_to_ID_bus[0]), 128'(in_mem));
    check("id_rf_wen", 128'(MEM_to_ID_bus[1]), 128'(in_mem && cur.en));
    check("id_load_pending", 128'(MEM_to_ID_bus[39]), 128'(in_mem && cur.re && !cur_done));
    if (in_mem) begin
      if (cur.re && cur_done)    fwd = load_val(cur);
      else if (cur.sel == 2'b01) fwd = cur.pc4 + 32'd4;
      else                       fwd = cur.alu;
      check("id_fwd_data", 128'(MEM_to_ID_bus[38:7]), 128'(fwd));
      check("id_rf_waddr", 128'(MEM_to_ID_bus[6:2]), 128'(cur.waddr));
    end

    if (aok) begin cur_reqd = 1; cur_dcnt = 1; end
    if (real_dok) cur_done = 1;
    if (rdy && wb) in_mem = 0;
    if (presenting && exp_allow) begin
      in_mem = 1; cur = pres; presenting = 0;
      cur_reqd = 0; cur_done = 0; cur_acnt = 0; cur_dcnt = 0; cur_stall = pres.wb_stall;
      exp_q.push_back(exp_wb(pres));
      if (is_mem(pres)) req_q.push_back(exp_req(pres));
    end
  endtask

  task automatic drain(int limit);
    int n = 0;
    while ((pend_q.size() > 0 || presenting || in_mem) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) check("drain_timeout", 128'(1), 128'(0));
    step();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_wb_valid"}, 128'(MEM_to_WB_valid), 128'(0));
    check({tag, "_req"}, 128'(data_sram_req), 128'(0));
    check({tag, "_allow_in"}, 128'(MEM_allow_in), 128'(1));
    check({tag, "_id_bits"}, 128'({MEM_to_ID_bus[39], MEM_to_ID_bus[1:0]}), 128'(0));
  endtask

  initial begin
    int n;
    reset = 1;
    EX_to_MEM_valid = 0; EX_to_MEM_bus = '0; WB_allow_in = 1;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
    presenting = 0; in_mem = 0; stray_en = 0; stray_force = 0;
    #2;
    check_reset_outputs("reset");
    #5 reset = 0;

    // LW with addr_ok one cycle after req and data_ok two cycles later
    mem_words[32'h100] = 32'h8899_AABB;
    pend_q.push_back(mk(1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 2, 0));
    drain(40);

    // byte/half loads, signed and unsigned
    mem_words[32'h100] = 32'h80FF_7F01;
    pend_q.push_back(mk(1, 0, 2'd0, 1, 32'h103, 32'h0, 0, 1, 0));
    pend_q.push_back(mk(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 0, 0));
    pend_q.push_back(mk(1, 0, 2'd1, 1, 32'h102, 32'h0, 2, 1, 0));
    pend_q.push_back(mk(1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 0, 0));
    drain(80);

    // stores: lane replication, byte enables, address alignment
    pend_q.push_back(mk(0, 1, 2'd0, 0, 32'h201, 32'h1234_56AB, 0, 1, 0));
    pend_q.push_back(mk(0, 1, 2'd1, 0, 32'h202, 32'h1234_56AB, 1, 1, 0));
    pend_q.push_back(mk(0, 1, 2'd2, 0, 32'h207, 32'h1234_56AB, 0, 0, 0));
    drain(80);

    // WB back-pressure while the load sits in DONE, with EX waiting behind it
    pend_q.push_back(mk(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, 1, 3));
    pend_q.push_back(mk(0, 0, 2'd2, 0, 32'h1234, 32'h0, 0, 0, 0));
    drain(40);

    // back-to-back ALU ops at full rate
    for (int i = 0; i < 8; i++) pend_q.push_back(mk(0, 0, 2'd2, 0, $urandom, $urandom, 0, 0, 0));
    drain(40);

    // reset while a load waits for data_ok, then a stray data_ok, then a clean LW
    pend_q.push_back(mk(1, 0, 2'd2, 0, 32'h400, 32'h0, 0, 30, 0));
    n = 0;
    while (!(in_mem && cur_reqd) && n < 20) begin step(); n++; end
    if (n >= 20) check("reset_setup_timeout", 128'(1), 128'(0));
    step();
    @(posedge clk);
    #2 reset = 1;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; EX_to_MEM_valid = 0;
    #1;
    check_reset_outputs("mid_reset");
    presenting = 0; in_mem = 0; pend_q.delete(); exp_q.delete(); req_q.delete();
    @(posedge clk);
    #2 reset = 0;
    stray_force = 1;
    step();
    step();
    mem_words[32'h500] = 32'hCAFE_F00D;
    pend_q.push_back(mk(1, 0, 2'd2, 0, 32'h500, 32'h0, 1, 2, 0));
    drain(40);

    // randomized mix with stray data_ok, random latencies and stalls
    ex_rate = 60;
    stray_en = 1;
    for (int i = 0; i < 150; i++) pend_q.push_back(rand_instr());
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
